sfx_mixer: RTL and testbench
============================

SFX_MIXER -- requirements
Module: sfx_mixer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent sound-effect channels (1..8).
REQ-002 Parameter ADDR_W, default 15: sample address width per channel.
REQ-003 Parameter DATA_W, default 24: signed sample width, for both ROM data and output.
REQ-004 Parameter TICK_DIV, default 1134: clock cycles per sample period (50 MHz / 1134 ≈ 44.1 kHz); minimum 4.
REQ-005 Parameter GAIN_SHIFT, default 4: left shift applied to the mixed sum before saturation.
REQ-006 clock  in  1  single system clock; all state on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low (0 = in reset); deasserted synchronously by the integrating design.
REQ-008 trig  in  NUM_CH  per-channel play request; level input, edge-detected internally.
REQ-009 stop  in  NUM_CH  per-channel abort; level, sampled every cycle.
REQ-010 loop_en  in  NUM_CH  per-channel: on reaching the end address, restart at address 0 instead of finishing.
REQ-011 retrig_en  in  NUM_CH  per-channel: a trig rising edge during play restarts the channel at address 0.
REQ-012 end_addr  in  NUM_CH*ADDR_W  per-channel last sample address, inclusive; channel c occupies bits [c*ADDR_W +: ADDR_W].
REQ-013 rom_addr  out  NUM_CH*ADDR_W  per-channel ROM address, packed as end_addr.
REQ-014 rom_q  in  NUM_CH*DATA_W  per-channel signed ROM data; synchronous ROM with 1-cycle read latency.
REQ-015 out_sample  out  DATA_W  signed mixed sample.
REQ-016 out_valid  out  1  out_sample holds an unconsumed sample.
REQ-017 out_ready  in  1  consumer (codec write_ready) accepts out_sample when out_valid=1 and out_ready=1.
REQ-018 busy  out  NUM_CH  channel is in the PLAY state.
REQ-019 done  out  NUM_CH  one-cycle pulse when a non-looping channel finishes naturally.
REQ-020 overrun  out  1  one-cycle pulse when an unconsumed sample is overwritten.

Function
REQ-021 Tick counter: counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle where count==TICK_DIV-1.
REQ-022 Each channel SHALL run a two-state FSM, IDLE/PLAY, with an address register addr[c].
REQ-023 Trigger edge: trig[c]=1 this cycle and 0 in the previous cycle, using a registered copy.
REQ-024 IDLE: a trig edge moves the channel to PLAY with addr=0 on the next edge; there is no other exit.
REQ-025 PLAY with tick and addr!=end_addr: addr increments by 1.
REQ-026 PLAY with tick and addr==end_addr: if loop_en[c], addr=0 and the channel stays in PLAY; otherwise the channel goes to IDLE, addr=0, and done[c] pulses for 1 cycle.
REQ-027 PLAY with a trig edge: if retrig_en[c], addr=0 and the channel stays in PLAY; otherwise the edge is ignored.
REQ-028 Priority per cycle: stop > trig edge > tick advance.
REQ-029 stop[c]=1: the channel goes to IDLE with addr=0, and done does not pulse.
REQ-030 end_addr=0: the channel plays a single sample per pass.
REQ-031 ADDR_W wrap: end_addr=2^ADDR_W-1 is legal; the increment never wraps past end_addr.
REQ-032 rom_addr[c] SHALL equal addr[c] directly from the register; IDLE channels present address 0.
REQ-033 Mix pipeline: with tick in cycle T, addr updates at the end of T and rom_q is valid in T+2. In T+2 the mixer sums rom_q[c] over channels whose busy[c] was 1 at the end of T, delayed to align.
REQ-034 Mix arithmetic:
- sum width is DATA_W+clog2(NUM_CH)+GAIN_SHIFT, sign-extended;
- shift arithmetic left by GAIN_SHIFT;
- saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-035 out_sample is registered at the end of T+2 and out_valid=1 from T+3; a sample is produced every tick, and it is 0 when no channel is active.
REQ-036 Handshake: out_valid clears on the edge after out_valid=1 and out_ready=1, unless a new sample loads on the same edge, in which case out_valid stays 1.
REQ-037 A new sample loading while out_valid=1 and out_ready=0 overwrites out_sample and pulses overrun.
REQ-038 out_sample SHALL be stable while out_valid=1 and no new sample loads.

Reset
REQ-039 While reset=0, all of the following SHALL hold asynchronously:
- FSMs IDLE, addr=0, tick counter 0, edge registers 0;
- pipeline cleared;
- out_sample=0, out_valid=0, busy=0, done=0, overrun=0.
REQ-040 Reset asserted mid-play aborts all channels, with no done pulse; after release, a trig held high from before reset does not start play until it goes low and then high again.

Verification
REQ-041 NUM_CH=2, TICK_DIV=4: trig[0] edge, end_addr[0]=3, loop_en=0 -> rom_addr[0] sequence 0,1,2,3; done[0] pulses once at the tick after address 3; busy[0] falls in the same cycle.
REQ-042 rom_q ch0=+100, ch1=-30, GAIN_SHIFT=4, both playing -> out_sample=1120; with ch0=2^23-1 and ch1=1 -> out_sample=8388607, saturated.
REQ-043 loop_en[1]=1, end_addr[1]=2 -> address cycles 0,1,2,0,1,... indefinitely; done[1] never pulses.
REQ-044 Mid-play trig edge at addr=5: retrig_en=1 -> next address is 0; retrig_en=0 -> next address is 6 at the next tick.
REQ-045 Handshake stalls:
- out_ready held 0 across two ticks -> overrun pulses once and out_sample shows the second sample;
- out_ready=1 in the same cycle a new sample loads -> out_valid stays 1.
REQ-046 Both channels playing, with stop[0] and a tick in the same cycle -> ch0 goes IDLE with addr=0 and no done pulse; ch1 advances normally. reset=0 asserted mid-play -> all outputs 0 immediately.

Source files
------------

// File: rtl/sfx_mixer.sv
// Multi-channel one-shot/looping sample player with a saturating mixer and a
// valid/ready output register that flags overwritten samples.
module sfx_mixer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned TICK_DIV   = 1134,
    parameter int unsigned GAIN_SHIFT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          trig,
    input  logic [NUM_CH-1:0]          stop,
    input  logic [NUM_CH-1:0]          loop_en,
    input  logic [NUM_CH-1:0]          retrig_en,
    input  logic [NUM_CH*ADDR_W-1:0]   end_addr,
    output logic [NUM_CH*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_CH*DATA_W-1:0]   rom_q,
    output logic signed [DATA_W-1:0]   out_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          done,
    output logic                       overrun
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SUM_W = DATA_W + CH_W + GAIN_SHIFT;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic {StIdle, StPlay} ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [ADDR_W-1:0] addr_q  [NUM_CH];
    logic [ADDR_W-1:0] addr_d  [NUM_CH];
    logic [NUM_CH-1:0] done_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick;
    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] armed_q;
    logic [NUM_CH-1:0] trig_edge;

    logic              tick_d1_q, tick_d2_q;
    logic [NUM_CH-1:0] mask_q;
    logic signed [SUM_W-1:0]  sum, scaled;
    logic signed [DATA_W-1:0] mix;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // armed_q blocks a trig held high across reset until it has been seen low.
    assign trig_edge = trig & ~trig_q & armed_q;

    always_comb begin
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            addr_d[c]  = addr_q[c];
            if (stop[c]) begin
                state_d[c] = StIdle;
                addr_d[c]  = '0;
            end else if (trig_edge[c] && (state_q[c] == StIdle || retrig_en[c])) begin
                state_d[c] = StPlay;
                addr_d[c]  = '0;
            end else if (state_q[c] == StPlay && tick) begin
                if (addr_q[c] != end_addr[c*ADDR_W +: ADDR_W]) begin
                    addr_d[c] = addr_q[c] + ADDR_W'(1);
                end else if (loop_en[c]) begin
                    addr_d[c] = '0;
                end else begin
                    state_d[c] = StIdle;
                    addr_d[c]  = '0;
                    done_d[c]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rom_addr = '0;
        busy     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rom_addr[c*ADDR_W +: ADDR_W] = addr_q[c];
            busy[c] = (state_q[c] == StPlay);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            trig_q  <= '0;
            armed_q <= '0;
            done    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= StIdle;
                addr_q[c]  <= '0;
            end
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
            trig_q  <= trig;
            armed_q <= armed_q | ~trig;
            done    <= done_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                addr_q[c]  <= addr_d[c];
            end
        end
    end

    // ROM data for a tick arrives two cycles later; mask_q holds the matching busy set.
    always_comb begin
        sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask_q[c]) begin
                sum = sum + SUM_W'(signed'(rom_q[c*DATA_W +: DATA_W]));
            end
        end
        scaled = sum <<< GAIN_SHIFT;
        if (scaled > SAT_MAX) begin
            mix = SAT_MAX[DATA_W-1:0];
        end else if (scaled < SAT_MIN) begin
            mix = SAT_MIN[DATA_W-1:0];
        end else begin
            mix = scaled[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_d1_q  <= 1'b0;
            tick_d2_q  <= 1'b0;
            mask_q     <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tick_d1_q <= tick;
            tick_d2_q <= tick_d1_q;
            if (tick_d1_q) begin
                mask_q <= busy;
            end
            if (tick_d2_q) begin
                out_sample <= mix;
                out_valid  <= 1'b1;
                overrun    <= out_valid & ~out_ready;
            end else begin
                overrun <= 1'b0;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_mixer.sv
// Randomized and directed bench for sfx_mixer against a behavioural player/mixer model.
module tb_sfx_mixer;

    localparam int NCH = 2;
    localparam int AW  = 4;
    localparam int DW  = 24;
    localparam int TD  = 4;

    logic                   clock;
    logic                   reset;
    logic [NCH-1:0]         trig, stop, loop_en, retrig_en;
    logic [NCH*AW-1:0]      end_addr;
    logic [NCH*AW-1:0]      rom_addr;
    logic [NCH*DW-1:0]      rom_q;
    logic signed [DW-1:0]   out_sample;
    logic                   out_valid;
    logic                   out_ready;
    logic [NCH-1:0]         busy, done;
    logic                   overrun;

    sfx_mixer #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD), .GAIN_SHIFT(4)
    ) dut (
        .clock(clock), .reset(reset), .trig(trig), .stop(stop), .loop_en(loop_en),
        .retrig_en(retrig_en), .end_addr(end_addr), .rom_addr(rom_addr), .rom_q(rom_q),
        .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sample ROM with one-cycle read latency.
    logic signed [DW-1:0] mem [NCH][16];
    always @(posedge clock) rom_q <= {mem[1][rom_addr[7:4]], mem[0][rom_addr[3:0]]};

    int vectors, miscompares;

    // Behavioural model state.
    int  m_cnt, cyc, m_loads;
    bit  m_play [NCH];
    int  m_addr [NCH];
    bit  m_prev [NCH];
    bit  m_seen_low [NCH];
    logic [NCH-1:0] m_done;
    logic m_valid, m_ovr;
    logic signed [DW-1:0] m_sample;
    typedef struct { int due; int val; } pend_t;
    pend_t pq[$];

    function automatic int expected_mix();
        longint s = 0;
        for (int c = 0; c < NCH; c++)
            if (m_play[c]) s += longint'(mem[c][m_addr[c]]);
        s = s * 16;
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return int'(s);
    endfunction

    function automatic logic [NCH*AW-1:0] m_rom_addr();
        return {AW'(m_addr[1]), AW'(m_addr[0])};
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        return {m_play[1], m_play[0]};
    endfunction

    task automatic model_init();
        m_cnt = 0; cyc = 0; m_loads = 0;
        for (int c = 0; c < NCH; c++) begin
            m_play[c] = 0; m_addr[c] = 0; m_prev[c] = 0; m_seen_low[c] = 0;
        end
        m_done = '0; m_valid = 0; m_ovr = 0; m_sample = '0;
        pq.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        bit tk, e;
        int ea;
        pend_t p;
        tk = (m_cnt == TD - 1);
        for (int c = 0; c < NCH; c++) begin
            e  = trig[c] && !m_prev[c] && m_seen_low[c];
            ea = int'(end_addr[c*AW +: AW]);
            m_done[c] = 1'b0;
            if (stop[c]) begin
                m_play[c] = 0; m_addr[c] = 0;
            end else if (e && (!m_play[c] || retrig_en[c])) begin
                m_play[c] = 1; m_addr[c] = 0;
            end else if (m_play[c] && tk) begin
                if (m_addr[c] != ea) m_addr[c] = m_addr[c] + 1;
                else if (loop_en[c]) m_addr[c] = 0;
                else begin
                    m_play[c] = 0; m_addr[c] = 0; m_done[c] = 1'b1;
                end
            end
            m_prev[c] = trig[c];
            if (!trig[c]) m_seen_low[c] = 1;
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            m_ovr = m_valid && !out_ready;
            m_sample = DW'(p.val);
            m_valid = 1'b1;
            m_loads++;
        end else begin
            m_ovr = 1'b0;
            if (m_valid && out_ready) m_valid = 1'b0;
        end
        if (tk) pq.push_back('{due: cyc + 2, val: expected_mix()});
        m_cnt = (m_cnt + 1) % TD;
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        model_init();
        reset = 1'b1;
    endtask

    task automatic fill_random_mem();
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 16; a++) mem[c][a] = DW'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors += 6;
        if (busy !== 2'b00) begin miscompares++; $display("FAIL reset_busy: got %b want 00", busy); end
        if (done !== 2'b00) begin miscompares++; $display("FAIL reset_done: got %b want 00", done); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_sample !== 24'sd0) begin miscompares++; $display("FAIL reset_sample: got %0d want 0", out_sample); end
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        if (rom_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
        model_init();
        reset = 1'b1;
    endtask

    task automatic test_single_shot();
        int seq[$];
        int dcnt;
        apply_reset();
        end_addr = {4'd5, 4'd3}; loop_en = 2'b00; retrig_en = 2'b00; stop = 2'b00; trig = 2'b00;
        step();
        trig[0] = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors += 3;
            if (rom_addr[3:0] !== AW'(m_addr[0])) begin
                miscompares++; $display("FAIL shot_addr: got %0d want %0d", rom_addr[3:0], m_addr[0]);
            end
            if (busy !== m_busy()) begin miscompares++; $display("FAIL shot_busy: got %b want %b", busy, m_busy()); end
            if (done !== m_done) begin miscompares++; $display("FAIL shot_done: got %b want %b", done, m_done); end
            if (busy[0] && (seq.size() == 0 || seq[$] != int'(rom_addr[3:0]))) seq.push_back(int'(rom_addr[3:0]));
            if (done[0]) begin
                dcnt++;
                vectors++;
                if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL shot_busy_fall: got %b want 0", busy[0]); end
            end
        end
        vectors += 2;
        if (seq.size() != 4) begin miscompares++; $display("FAIL shot_seq_len: got %0d want 4", seq.size()); end
        else for (int i = 0; i < 4; i++) begin
            vectors++;
            if (seq[i] != i) begin miscompares++; $display("FAIL shot_seq[%0d]: got %0d want %0d", i, seq[i], i); end
        end
        if (dcnt != 1) begin miscompares++; $display("FAIL shot_done_count: got %0d want 1", dcnt); end
    endtask

    task automatic test_mix();
        int v0 [3] = '{100, 8388607, -8388608};
        int v1 [3] = '{-30, 1, -1};
        int exp_out [3] = '{1120, 8388607, -8388608};
        apply_reset();
        end_addr = {4'd3, 4'd3}; loop_en = 2'b11; retrig_en = 2'b00; stop = 2'b00; trig = 2'b00;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 16; a++) begin mem[0][a] = DW'(v0[k]); mem[1][a] = DW'(v1[k]); end
            if (k == 0) begin step(); trig = 2'b11; end
            repeat (16) step();
            vectors += 2;
            if (out_sample !== DW'(exp_out[k])) begin
                miscompares++; $display("FAIL mix_const%0d: got %0d want %0d", k, out_sample, exp_out[k]);
            end
            if (out_sample !== m_sample) begin
                miscompares++; $display("FAIL mix_model%0d: got %0d want %0d", k, out_sample, m_sample);
            end
        end
    endtask

    task automatic test_loop();
        int seq[$];
        int dcnt;
        apply_reset();
        end_addr = {4'd2, 4'd0}; loop_en = 2'b10; retrig_en = 2'b00; stop = 2'b00; trig = 2'b00;
        step();
        trig[1] = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            vectors++;
            if (rom_addr[7:4] !== AW'(m_addr[1])) begin
                miscompares++; $display("FAIL loop_addr: got %0d want %0d", rom_addr[7:4], m_addr[1]);
            end
            if (done[1]) dcnt++;
            if (busy[1] && (seq.size() == 0 || seq[$] != int'(rom_addr[7:4]))) seq.push_back(int'(rom_addr[7:4]));
        end
        vectors += 3;
        if (dcnt != 0) begin miscompares++; $display("FAIL loop_done: got %0d pulses want 0", dcnt); end
        if (busy[1] !== 1'b1) begin miscompares++; $display("FAIL loop_busy: got %b want 1", busy[1]); end
        if (seq.size() < 12) begin miscompares++; $display("FAIL loop_seq_len: got %0d want >=12", seq.size()); end
        else for (int i = 0; i < 12; i++) begin
            vectors++;
            if (seq[i] != i % 3) begin miscompares++; $display("FAIL loop_seq[%0d]: got %0d want %0d", i, seq[i], i % 3); end
        end
    endtask

    task automatic test_retrig();
        int n;
        for (int r = 1; r >= 0; r--) begin
            apply_reset();
            end_addr = {4'd0, 4'd10}; loop_en = 2'b00; retrig_en = {1'b0, r[0]};
            stop = 2'b00; trig = 2'b00;
            step();
            trig[0] = 1'b1;
            n = 0;
            while (!(m_play[0] && m_addr[0] == 5) && n < 60) begin step(); n++; end
            vectors++;
            if (n >= 60) begin miscompares++; $display("FAIL retrig_reach5: got timeout want addr 5"); end
            trig[0] = 1'b0; step();
            trig[0] = 1'b1; step();
            vectors += 2;
            if (rom_addr[3:0] !== (r ? 4'd0 : 4'd5)) begin
                miscompares++; $display("FAIL retrig%0d_edge: got %0d want %0d", r, rom_addr[3:0], r ? 0 : 5);
            end
            if (rom_addr !== m_rom_addr()) begin
                miscompares++; $display("FAIL retrig%0d_model: got %h want %h", r, rom_addr, m_rom_addr());
            end
            repeat (2) step();
            vectors++;
            if (rom_addr[3:0] !== (r ? 4'd1 : 4'd6)) begin
                miscompares++; $display("FAIL retrig%0d_next: got %0d want %0d", r, rom_addr[3:0], r ? 1 : 6);
            end
        end
    endtask

    task automatic test_handshake();
        int start_loads, ocnt, n;
        apply_reset();
        fill_random_mem();
        end_addr = {4'd7, 4'd9}; loop_en = 2'b11; retrig_en = 2'b00; stop = 2'b00;
        trig = 2'b00; out_ready = 1'b1;
        step();
        trig = 2'b11;
        out_ready = 1'b0;
        start_loads = m_loads;
        ocnt = 0; n = 0;
        while (m_loads < start_loads + 2 && n < 12) begin
            step(); n++;
            vectors += 3;
            if (overrun !== m_ovr) begin miscompares++; $display("FAIL hs_ovr: got %b want %b", overrun, m_ovr); end
            if (out_valid !== m_valid) begin miscompares++; $display("FAIL hs_valid: got %b want %b", out_valid, m_valid); end
            if (out_sample !== m_sample) begin miscompares++; $display("FAIL hs_sample: got %0d want %0d", out_sample, m_sample); end
            if (overrun) ocnt++;
        end
        vectors += 2;
        if (n >= 12) begin miscompares++; $display("FAIL hs_loads: got timeout want 2 loads"); end
        if (ocnt != 1) begin miscompares++; $display("FAIL hs_ovr_count: got %0d want 1", ocnt); end
        // Raise ready exactly on the cycle a new sample loads.
        n = 0;
        while (!(pq.size() > 0 && pq[0].due == cyc) && n < 8) begin step(); n++; end
        out_ready = 1'b1;
        step();
        vectors += 3;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hs_load_accept_valid: got %b want 1", out_valid); end
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL hs_load_accept_ovr: got %b want 0", overrun); end
        if (out_sample !== m_sample) begin miscompares++; $display("FAIL hs_load_sample: got %0d want %0d", out_sample, m_sample); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hs_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stop();
        int a1, n;
        apply_reset();
        end_addr = {4'd12, 4'd12}; loop_en = 2'b00; retrig_en = 2'b00; stop = 2'b00; trig = 2'b00;
        step();
        trig = 2'b11;
        repeat (6) step();
        n = 0;
        while (m_cnt != TD - 1 && n < 8) begin step(); n++; end
        a1 = m_addr[1];
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        vectors += 5;
        if (busy !== 2'b10) begin miscompares++; $display("FAIL stop_busy: got %b want 10", busy); end
        if (rom_addr[3:0] !== 4'd0) begin miscompares++; $display("FAIL stop_addr0: got %0d want 0", rom_addr[3:0]); end
        if (done !== 2'b00) begin miscompares++; $display("FAIL stop_done: got %b want 00", done); end
        if (rom_addr[7:4] !== AW'(a1 + 1)) begin
            miscompares++; $display("FAIL stop_ch1_adv: got %0d want %0d", rom_addr[7:4], a1 + 1);
        end
        if (rom_addr !== m_rom_addr()) begin miscompares++; $display("FAIL stop_model: got %h want %h", rom_addr, m_rom_addr()); end
    endtask

    task automatic test_reset_midplay();
        int n;
        apply_reset();
        fill_random_mem();
        mem[0][0] = 24'sd5000;
        end_addr = {4'd9, 4'd9}; loop_en = 2'b11; retrig_en = 2'b00; stop = 2'b00;
        trig = 2'b00; out_ready = 1'b0;
        step();
        trig = 2'b11;
        repeat (14) step();
        #2 reset = 1'b0;
        #1;
        vectors += 6;
        if (busy !== 2'b00) begin miscompares++; $display("FAIL midrst_busy: got %b want 00", busy); end
        if (done !== 2'b00) begin miscompares++; $display("FAIL midrst_done: got %b want 00", done); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        if (out_sample !== 24'sd0) begin miscompares++; $display("FAIL midrst_sample: got %0d want 0", out_sample); end
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_ovr: got %b want 0", overrun); end
        if (rom_addr !== 8'h00) begin miscompares++; $display("FAIL midrst_addr: got %h want 00", rom_addr); end
        @(negedge clock);
        out_ready = 1'b1;
        apply_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (busy !== 2'b00) begin miscompares++; $display("FAIL held_trig_busy: got %b want 00", busy); end
        end
        trig = 2'b00; step();
        trig = 2'b11; step();
        vectors += 2;
        if (busy !== 2'b11) begin miscompares++; $display("FAIL rearm_busy: got %b want 11", busy); end
        if (busy !== m_busy()) begin miscompares++; $display("FAIL rearm_model: got %b want %b", busy, m_busy()); end
    endtask

    task automatic test_random();
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            fill_random_mem();
            end_addr = {AW'($urandom_range(0, 15)), (pass == 0) ? 4'd15 : 4'd0};
            loop_en = 2'($urandom); retrig_en = 2'($urandom); stop = 2'b00; trig = 2'b00;
            for (int i = 0; i < 600; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 7) == 0) trig[c] = ~trig[c];
                    stop[c] = ($urandom_range(0, 39) == 0);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (i % 100 == 99) begin loop_en = 2'($urandom); retrig_en = 2'($urandom); end
                step();
                vectors += 6;
                if (rom_addr !== m_rom_addr()) begin miscompares++; $display("FAIL rnd_addr @%0d: got %h want %h", i, rom_addr, m_rom_addr()); end
                if (busy !== m_busy()) begin miscompares++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, m_busy()); end
                if (done !== m_done) begin miscompares++; $display("FAIL rnd_done @%0d: got %b want %b", i, done, m_done); end
                if (out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid @%0d: got %b want %b", i, out_valid, m_valid); end
                if (out_sample !== m_sample) begin miscompares++; $display("FAIL rnd_sample @%0d: got %0d want %0d", i, out_sample, m_sample); end
                if (overrun !== m_ovr) begin miscompares++; $display("FAIL rnd_ovr @%0d: got %b want %b", i, overrun, m_ovr); end
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; trig = '0; stop = '0; loop_en = '0; retrig_en = '0;
        end_addr = '0; out_ready = 1'b1;
        fill_random_mem();
        model_init();
        @(negedge clock);
        test_reset();
        test_single_shot();
        test_mix();
        test_loop();
        test_retrig();
        test_handshake();
        test_stop();
        test_reset_midplay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
